freg_arbiter: RTL and testbench

//  Shares the single-port file-register array between the CPU core and a host/debug port.

---
 rtl/freg_arbiter.sv | 108 ++++++++++
 tb/tb_freg_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freg_arbiter.sv
// Arbitrates the single-port file-register array between the CPU core and a host/debug port.
// Core has priority; a starved or halting host is granted, and 1-cycle read data is routed back to its owner.
module freg_arbiter #(
    parameter int DWIDTH            = 8,
    parameter int L2_NUM_FREG       = 5,
    parameter int HOST_STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [L2_NUM_FREG-1:0] core_addr,
    input  logic                   core_rden,
    input  logic                   core_wren,
    input  logic [DWIDTH-1:0]      core_wdata,
    output logic [DWIDTH-1:0]      core_rdata,
    output logic                   core_stall,
    input  logic                   host_halt,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [L2_NUM_FREG-1:0] host_addr,
    input  logic [DWIDTH-1:0]      host_wdata,
    output logic                   host_gnt,
    output logic                   host_rvalid,
    output logic [DWIDTH-1:0]      host_rdata,
    output logic [L2_NUM_FREG-1:0] rf_addr,
    output logic                   rf_rden,
    output logic                   rf_wren,
    output logic [DWIDTH-1:0]      rf_wdata,
    input  logic [DWIDTH-1:0]      rf_rdata
);

    localparam int CW = $clog2(HOST_STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(HOST_STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_HOST
    } owner_e;

    logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DWIDTH-1:0] core_hold_q, core_hold_d;

    logic core_act;
    logic core_go;
    logic starved;
    logic host_rd;

    always_comb begin
        core_act   = core_rden | core_wren;
        starved    = (starve_cnt_q == STARVE_MAX);
        host_gnt   = ~rst & host_req & (host_halt | ~core_act | starved);
        core_stall = rst | host_halt | (core_act & host_gnt);
        core_go    = core_act & ~core_stall;
        host_rd    = host_gnt & ~host_we;

        rf_addr  = core_addr;
        rf_wdata = core_wdata;
        rf_rden  = 1'b0;
        rf_wren  = 1'b0;
        if (host_gnt) begin
            rf_addr  = host_addr;
            rf_wdata = host_wdata;
            rf_rden  = ~host_we;
            rf_wren  = host_we;
        end else if (core_go) begin
            rf_rden = core_rden;
            rf_wren = core_wren;
        end

        // Registered read results are masked while rst is high so an in-flight read is dropped.
        host_rvalid = host_rvalid_q & ~rst;
        host_rdata  = host_rvalid ? rf_rdata : '0;
        core_rdata  = (rd_owner_q == OWN_CORE && !rst) ? rf_rdata : core_hold_q;
        core_hold_d = core_rdata;

        starve_cnt_d = starve_cnt_q;
        if (host_gnt || !host_req) begin
            starve_cnt_d = '0;
        end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end

        rd_owner_d = OWN_NONE;
        if (host_rd) begin
            rd_owner_d = OWN_HOST;
        end else if (core_go && core_rden) begin
            rd_owner_d = OWN_CORE;
        end
        host_rvalid_d = host_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q  <= '0;
            rd_owner_q    <= OWN_NONE;
            host_rvalid_q <= 1'b0;
            core_hold_q   <= '0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            rd_owner_q    <= rd_owner_d;
            host_rvalid_q <= host_rvalid_d;
            core_hold_q   <= core_hold_d;
        end
    end

endmodule

// File: tb/tb_freg_arbiter.sv
// Bench for freg_arbiter: directed scenarios plus random traffic against a rule-level reference
// model; a simple 1-cycle-latency register file is attached to the rf_* ports.
module tb_freg_arbiter;

    localparam int LIMIT = 4;

    logic       clk;
    logic       rst;
    logic [4:0] core_addr;
    logic       core_rden;
    logic       core_wren;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata;
    logic       core_stall;
    logic       host_halt;
    logic       host_req;
    logic       host_we;
    logic [4:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic [4:0] rf_addr;
    logic       rf_rden;
    logic       rf_wren;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata;

    freg_arbiter #(
        .DWIDTH(8),
        .L2_NUM_FREG(5),
        .HOST_STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .core_addr(core_addr), .core_rden(core_rden), .core_wren(core_wren),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_halt(host_halt), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .rf_addr(rf_addr), .rf_rden(rf_rden), .rf_wren(rf_wren),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file stand-in; mem_init loads the known power-up contents.
    logic       mem_init;
    logic [7:0] tb_mem [32];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= (i == 17) ? 8'h33 : 8'h00;
            rf_rdata <= 8'h00;
        end else begin
            if (rf_wren) tb_mem[rf_addr] <= rf_wdata;
            if (rf_rden) rf_rdata <= tb_mem[rf_addr];
        end
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state: starvation count, pending read (0 none, 1 core, 2 host), shadow memory.
    int         m_starve = 0;
    int         m_pend   = 0;
    logic [7:0] m_pdata  = 8'h00;
    logic [7:0] m_hold   = 8'h00;
    logic       m_gnt    = 1'b0;
    logic [7:0] smem [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic crd, input logic cwr, input logic [4:0] ca,
                         input logic [7:0] cwd, input logic hh, input logic hr, input logic hw,
                         input logic [4:0] ha, input logic [7:0] hwd);
        rst = r; core_rden = crd; core_wren = cwr; core_addr = ca; core_wdata = cwd;
        host_halt = hh; host_req = hr; host_we = hw; host_addr = ha; host_wdata = hwd;
    endtask

    task automatic step();
        logic       ca, e_gnt, e_stall, e_rd, e_wr, e_hv;
        logic [4:0] e_addr;
        logic [7:0] e_wd, e_hd, e_cr;
        @(negedge clk);
        ca      = core_rden | core_wren;
        e_gnt   = !rst && host_req && (host_halt || !ca || m_starve == LIMIT);
        e_stall = rst || host_halt || (ca && e_gnt);
        e_addr  = core_addr; e_wd = core_wdata; e_rd = 1'b0; e_wr = 1'b0;
        if (e_gnt) begin
            e_addr = host_addr; e_wd = host_wdata; e_rd = !host_we; e_wr = host_we;
        end else if (ca && !e_stall) begin
            e_rd = core_rden; e_wr = core_wren;
        end
        e_hv = !rst && m_pend == 2;
        e_hd = e_hv ? m_pdata : 8'h00;
        e_cr = (!rst && m_pend == 1) ? m_pdata : m_hold;

        check("host_gnt", 32'(host_gnt), 32'(e_gnt));
        check("core_stall", 32'(core_stall), 32'(e_stall));
        check("rf_addr", 32'(rf_addr), 32'(e_addr));
        check("rf_rden", 32'(rf_rden), 32'(e_rd));
        check("rf_wren", 32'(rf_wren), 32'(e_wr));
        if (e_wr) check("rf_wdata", 32'(rf_wdata), 32'(e_wd));
        check("host_rvalid", 32'(host_rvalid), 32'(e_hv));
        check("host_rdata", 32'(host_rdata), 32'(e_hd));
        check("core_rdata", 32'(core_rdata), 32'(e_cr));

        if (rst) begin
            m_starve = 0; m_pend = 0; m_hold = 8'h00;
        end else begin
            if (m_pend == 1) m_hold = m_pdata;
            m_starve = (e_gnt || !host_req) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
            m_pend = 0;
            if (e_rd) begin
                m_pend  = e_gnt ? 2 : 1;
                m_pdata = smem[e_addr];
            end
            if (e_wr) smem[e_addr] = e_wd;
        end
        m_gnt = e_gnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       halt_s, h_req, h_we;
        logic [4:0] h_addr;
        logic [7:0] h_wd;

        for (int i = 0; i < 32; i++) smem[i] = (i == 17) ? 8'h33 : 8'h00;
        mem_init = 1'b1;
        drive(1, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00);
        step();
        step();
        mem_init = 1'b0;

        // Reset with both masters requesting: nothing may reach the register file.
        drive(1, 1, 1, 5'h03, 8'hFF, 0, 1, 1, 5'h04, 8'hEE);
        #2;
        check("rst_gnt", 32'(host_gnt), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd1);
        check("rst_wren", 32'(rf_wren), 32'd0);
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_core_rdata", 32'(core_rdata), 32'd0);
        step();

        // Core write then read with idle host.
        drive(0, 0, 1, 5'h10, 8'h5A, 0, 0, 0, 5'h00, 8'h00);
        step();
        drive(0, 1, 0, 5'h10, 8'h00, 0, 0, 0, 5'h00, 8'h00);
        #2;
        check("t1_stall", 32'(core_stall), 32'd0);
        step();
        drive(0, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00);
        #2;
        check("t1_core_rdata", 32'(core_rdata), 32'h5A);
        step();

        // Host read with idle core.
        drive(0, 0, 0, 5'h00, 8'h00, 0, 1, 0, 5'h11, 8'h00);
        #2;
        check("t2_gnt", 32'(host_gnt), 32'd1);
        step();
        drive(0, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00);
        #2;
        check("t2_rvalid", 32'(host_rvalid), 32'd1);
        check("t2_rdata", 32'(host_rdata), 32'h33);
        step();

        // Starvation: busy core, host held; grant on the (LIMIT+1)th cycle, then counter restarts.
        for (int i = 0; i < LIMIT + 2; i++) begin
            drive(0, 1, 0, 5'(i), 8'h00, 0, 1, 0, 5'h02, 8'h00);
            #2;
            check("t3_gnt", 32'(host_gnt), (i == LIMIT) ? 32'd1 : 32'd0);
            if (i == LIMIT) check("t3_stall", 32'(core_stall), 32'd1);
            step();
        end

        // Halt: host writes then reads back while the core keeps reading.
        drive(0, 1, 0, 5'h01, 8'h00, 1, 1, 1, 5'h12, 8'hA5);
        #2;
        check("t4_stall", 32'(core_stall), 32'd1);
        check("t4_wren", 32'(rf_wren), 32'd1);
        step();
        drive(0, 1, 0, 5'h01, 8'h00, 1, 1, 0, 5'h12, 8'h00);
        step();
        drive(0, 1, 0, 5'h01, 8'h00, 1, 0, 0, 5'h00, 8'h00);
        #2;
        check("t4_rdata", 32'(host_rdata), 32'hA5);
        check("t4_core_rden", 32'(rf_rden), 32'd0);
        step();

        // Reset right after a granted host read drops the result.
        drive(0, 0, 0, 5'h00, 8'h00, 0, 1, 0, 5'h11, 8'h00);
        step();
        drive(1, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00);
        #2;
        check("t5_rvalid", 32'(host_rvalid), 32'd0);
        check("t5_stall", 32'(core_stall), 32'd1);
        check("t5_rden", 32'(rf_rden), 32'd0);
        step();
        for (int i = 0; i < LIMIT + 1; i++) begin
            drive(0, 1, 0, 5'(i), 8'h00, 0, 1, 1, 5'h05, 8'h11);
            #2;
            check("t5_gnt", 32'(host_gnt), (i == LIMIT) ? 32'd1 : 32'd0);
            step();
        end

        // Host write followed by core read of the same address.
        drive(0, 0, 0, 5'h00, 8'h00, 0, 1, 1, 5'h13, 8'h77);
        step();
        drive(0, 1, 0, 5'h13, 8'h00, 0, 0, 0, 5'h00, 8'h00);
        step();
        drive(0, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00);
        #2;
        check("t6_core_rdata", 32'(core_rdata), 32'h77);
        step();

        // Random traffic; host keeps its request stable until granted.
        halt_s = 1'b0; h_req = 1'b0; h_we = 1'b0; h_addr = 5'h00; h_wd = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) halt_s = ~halt_s;
            if (!(h_req && !m_gnt)) begin
                h_req  = ($urandom_range(0, 2) != 0);
                h_we   = 1'($urandom_range(0, 1));
                h_addr = 5'($urandom_range(0, 7));
                h_wd   = 8'($urandom_range(0, 255));
            end
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), halt_s, h_req, h_we, h_addr, h_wd);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
